// File: rtl/text_tile_engine.sv
// Text-mode tile engine: 8x16 glyph cells over a COLS x ROWS character RAM, fed by a byte-stream cursor port.
// Optional cursor blink is built when CURSOR_BLINK_EN is defined; otherwise the cursor is always inverted.

module fontrom (
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);
    localparam logic [127:0] GLYPH_A = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
    localparam logic [127:0] GLYPH_B = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;

    logic [7:0] word;

    // Row 0 of a glyph sits in the top byte.
    always_comb begin
        word = 8'h00;
        case (addr[10:4])
            7'h41:   word = 8'(GLYPH_A >> {4'd15 - addr[3:0], 3'b000});
            7'h42:   word = 8'(GLYPH_B >> {4'd15 - addr[3:0], 3'b000});
            default: word = 8'h00;
        endcase
    end

    always_ff @(posedge clk) data <= word;
endmodule

module text_tile_engine #(
    parameter int          COLS         = 80,
    parameter int          ROWS         = 30,
    parameter logic [23:0] FG_RGB       = 24'hFF1020,
    parameter logic [23:0] BG_RGB       = 24'h000000,
    parameter int          BLINK_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       busy,
    output logic [6:0] cur_col,
    output logic [5:0] cur_row,
    output logic [7:0] red_out,
    output logic [7:0] green_out,
    output logic [7:0] blue_out
);
    localparam int          DEPTH   = COLS * ROWS;
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          STAGES  = 2;
    localparam logic [6:0]  COL_MAX = 7'(COLS - 1);
    localparam logic [5:0]  ROW_MAX = 6'(ROWS - 1);
    localparam logic [7:0]  COLS_W  = 8'(COLS);
    localparam logic [6:0]  ROWS_W  = 7'(ROWS);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    function automatic logic [AW-1:0] cell_addr(input logic [6:0] c, input logic [5:0] r);
        logic [13:0] a;
        a = 14'(r) * 14'(COLS) + 14'(c);
        return AW'(a);
    endfunction

    state_t        state, nxt_state;
    logic [AW-1:0] clr_addr;
    logic          we;
    logic [AW-1:0] waddr;
    logic [6:0]    wdata;
    logic [6:0]    nxt_col;
    logic [5:0]    nxt_row;

    wire accept   = (state == IDLE) && char_valid;
    wire is_print = (char_data >= 8'h20) && (char_data <= 8'h7E);
    wire is_nl    = (char_data == 8'h0A);
    wire is_bs    = (char_data == 8'h08);
    wire is_clr   = (char_data == 8'h0C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= CLEAR;
        else       state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            CLEAR:   if (clr_addr == LAST) nxt_state = IDLE;
            IDLE:    if (accept && is_clr) nxt_state = CLEAR;
            default: nxt_state = CLEAR;
        endcase
    end

    always_comb begin
        busy  = (state == CLEAR);
        we    = 1'b0;
        waddr = clr_addr;
        wdata = 7'h20;
        if (state == CLEAR) begin
            we = 1'b1;
        end else if (accept && is_print) begin
            we    = 1'b1;
            waddr = cell_addr(cur_col, cur_row);
            wdata = char_data[6:0];
        end
    end

    // Sweep pointer idles at zero so every entry into CLEAR starts from cell 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                    clr_addr <= '0;
        else if (state == CLEAR && clr_addr != LAST)  clr_addr <= clr_addr + 1'b1;
        else                                          clr_addr <= '0;
    end

    always_comb begin
        nxt_col = cur_col;
        nxt_row = cur_row;
        if (accept) begin
            if (is_print && cur_col != COL_MAX) begin
                nxt_col = cur_col + 7'd1;
            end else if (is_print || is_nl) begin
                nxt_col = '0;
                nxt_row = (cur_row == ROW_MAX) ? '0 : cur_row + 6'd1;
            end else if (is_bs) begin
                if (cur_col != '0) begin
                    nxt_col = cur_col - 7'd1;
                end else if (cur_row != '0) begin
                    nxt_col = COL_MAX;
                    nxt_row = cur_row - 6'd1;
                end
            end else if (is_clr) begin
                nxt_col = '0;
                nxt_row = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_col <= '0;
            cur_row <= '0;
        end else begin
            cur_col <= nxt_col;
            cur_row <= nxt_row;
        end
    end

    logic inv_en;
`ifdef CURSOR_BLINK_EN
    logic [31:0] blink_cnt;
    logic        blink_phase;
    wire         cur_move = (nxt_col != cur_col) || (nxt_row != cur_row);

    // Any cursor move restarts the phase visible so freshly typed text shows the cursor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || cur_move) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == 32'(BLINK_CYCLES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 32'd1;
        end
    end
    assign inv_en = blink_phase;
`else
    assign inv_en = 1'b1;
`endif

    logic [6:0]    mem [DEPTH];
    logic [6:0]    rd_char;
    logic [7:0]    font_word;
    logic [AW-1:0] raddr;
    logic [STAGES:1] vld_pipe;
    logic [6:0]    col1, col2;
    logic [5:0]    row1, row2;
    logic [2:0]    xb1, xb2;
    logic [3:0]    yb1;

    wire in_grid0 = ({1'b0, pixel_x[9:3]} < COLS_W) && ({1'b0, pixel_y[9:4]} < ROWS_W);
    assign raddr = in_grid0 ? cell_addr(pixel_x[9:3], pixel_y[9:4]) : '0;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rd_char <= mem[raddr];
    end

    fontrom u_font (.clk(clk), .addr({rd_char, yb1}), .data(font_word));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            {col1, row1, xb1, yb1} <= '0;
            {col2, row2, xb2}      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], video_on};
            {col1, row1, xb1, yb1} <= {pixel_x[9:3], pixel_y[9:4], pixel_x[2:0], pixel_y[3:0]};
            {col2, row2, xb2}      <= {col1, row1, xb1};
        end
    end

    logic [23:0] rgb;
    wire in_grid2 = ({1'b0, col2} < COLS_W) && ({1'b0, row2} < ROWS_W);
    wire is_cur2  = (col2 == cur_col) && (row2 == cur_row);

    always_comb begin
        rgb = 24'h0;
        if (vld_pipe[STAGES]) begin
            if (!in_grid2)                                         rgb = BG_RGB;
            else if (font_word[~xb2] ^ (is_cur2 & inv_en))         rgb = FG_RGB;
            else                                                   rgb = BG_RGB;
        end
    end

    assign {red_out, green_out, blue_out} = rgb;
endmodule
